operand_fetch_stage: RTL and testbench

- Pipeline stage directly upstream of the 8x8 register file's consumers: accepts decoded instructions, drives the register file read addresses and captures the returned operands into an output pipeline register for the ALU/execute stage.
- Provides writeback-to-read bypass, because a register file write lands only at the next posedge.
- Holds a per-register busy scoreboard so dependent instructions stall until their producer writes back.
- Valid/ready handshake on both sides.

---
 rtl/operand_fetch_stage.sv | 117 +++++++++++
 tb/tb_operand_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, bypasses same-cycle writeback, stalls on busy-register hazards.
// Accept-to-out_valid latency is 1 cycle; in_ready drops on hazard or when the held output is not taken.
module operand_fetch_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wr,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_opcode,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int NREG = 2**ADDR_W;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] rd;
    logic              wr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  op_t               out_q;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic [DATA_W-1:0] opb;
  logic              raw1;
  logic              raw2;
  logic              waw;
  logic              hazard;
  logic              space;
  logic              fire;
  logic              stall;
  logic [NREG-1:0]   busy_nxt;

  assign rf_read_addr1 = in_rs1;
  assign rf_read_addr2 = in_rs2;

  // The register file write only lands at the next edge, so pick up writeback data here.
  assign fwd1 = (wb_en && wb_addr == in_rs1) ? wb_data : rf_read_data1;
  assign fwd2 = (wb_en && wb_addr == in_rs2) ? wb_data : rf_read_data2;
  assign opb  = in_use_imm ? in_imm : fwd2;

  assign raw1   = busy[in_rs1] && !(wb_en && wb_addr == in_rs1);
  assign raw2   = !in_use_imm && busy[in_rs2] && !(wb_en && wb_addr == in_rs2);
  assign waw    = in_wr && busy[in_rd] && !(wb_en && wb_addr == in_rd);
  assign hazard = raw1 | raw2 | waw;

  assign space    = !out_valid || out_ready;
  assign in_ready = space && !hazard;
  assign fire     = in_valid && in_ready;
  assign stall    = in_valid && !in_ready;

  // Clear first so a same-cycle set on the same register takes priority.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)
      busy_nxt[wb_addr] = 1'b0;
    if (fire && in_wr)
      busy_nxt[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      busy      <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire) begin
        out_q.opcode <= in_opcode;
        out_q.rd     <= in_rd;
        out_q.wr     <= in_wr;
        out_q.a      <= fwd1;
        out_q.b      <= opb;
        out_valid    <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      busy <= busy_nxt;
      if (stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_opcode = out_q.opcode;
  assign out_rd     = out_q.rd;
  assign out_wr     = out_q.wr;
  assign out_a      = out_q.a;
  assign out_b      = out_q.b;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: register file model, expected-result queue, per-feature tasks.
module tb_operand_fetch_stage;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;
  localparam int NREG   = 2**ADDR_W;
  localparam int EXP_W  = OP_W + ADDR_W + 1 + 2*DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode = '0;
  logic [ADDR_W-1:0] in_rd = '0;
  logic              in_wr = 1'b0;
  logic [ADDR_W-1:0] in_rs1 = '0;
  logic [ADDR_W-1:0] in_rs2 = '0;
  logic              in_use_imm = 1'b0;
  logic [DATA_W-1:0] in_imm = '0;
  logic [ADDR_W-1:0] rf_read_addr1;
  logic [ADDR_W-1:0] rf_read_addr2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic              wb_en = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OP_W-1:0]   out_opcode;
  logic [ADDR_W-1:0] out_rd;
  logic              out_wr;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] rf [NREG];
  logic [EXP_W-1:0]  exp_q [$];

  always #5 clk = ~clk;

  operand_fetch_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_wr(in_wr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_wr(out_wr), .out_a(out_a), .out_b(out_b), .busy(busy), .stall_cnt(stall_cnt)
  );

  // Register file model: written at the edge, read combinationally.
  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = DATA_W'(i * 8'h11);
    rf[1] = 8'h12;
    rf[2] = 8'h34;
  end
  always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;
  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];

  // Inputs change just after posedge; mid-cycle negedge sees settled values for the coming edge.
  always @(negedge clk) begin
    logic [DATA_W-1:0] ea, eb;
    if (rst_n && in_valid && in_ready) begin
      ea = (wb_en && wb_addr == in_rs1) ? wb_data : rf[in_rs1];
      eb = in_use_imm ? in_imm : ((wb_en && wb_addr == in_rs2) ? wb_data : rf[in_rs2]);
      exp_q.push_back({in_opcode, in_rd, in_wr, ea, eb});
    end
  end

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got op=%h rd=%0d wr=%b a=%h b=%h, expected nothing",
                 out_opcode, out_rd, out_wr, out_a, out_b);
      end else begin
        e = exp_q.pop_front();
        if ({out_opcode, out_rd, out_wr, out_a, out_b} !== e) begin
          bad++;
          $display("FAIL scoreboard: got %h expected %h", {out_opcode, out_rd, out_wr, out_a, out_b}, e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rd, input logic wr,
                       input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                       input logic use_imm, input logic [DATA_W-1:0] imm);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_rd      = rd;
    in_wr      = wr;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_use_imm = use_imm;
    in_imm     = imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue(4'h1, 3'd1, 1'b1, 3'd1, 3'd2, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_busy: got %h expected 00", busy); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    total++; if ({out_a, out_b, out_rd, out_opcode, out_wr} !== '0) begin
      bad++; $display("FAIL reset_out_regs: got a=%h b=%h rd=%0d op=%h wr=%b expected zeros", out_a, out_b, out_rd, out_opcode, out_wr);
    end
    next_cycle();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    next_cycle();
    issue(4'h5, 3'd3, 1'b1, 3'd1, 3'd2, 1'b0, 8'h00);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_accept: got in_ready=%b expected 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    total++; if (out_a !== 8'h12 || out_b !== 8'h34) begin bad++; $display("FAIL basic_operands: got a=%h b=%h expected a=12 b=34", out_a, out_b); end
    total++; if (out_rd !== 3'd3 || out_opcode !== 4'h5) begin bad++; $display("FAIL basic_rd_op: got rd=%0d op=%h expected rd=3 op=5", out_rd, out_opcode); end
    total++; if (busy !== 8'h08) begin bad++; $display("FAIL basic_busy: got %h expected 08", busy); end
  endtask

  task automatic test_raw_stall();
    next_cycle();
    issue(4'h6, 3'd5, 1'b0, 3'd3, 3'd0, 1'b1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall_cycle%0d: got in_ready=%b expected 0", i, in_ready); end
      next_cycle();
    end
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h46;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_release: got in_ready=%b expected 1", in_ready); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL raw_stall_cnt: got %0d expected 3", stall_cnt); end
    next_cycle();
    wb_en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_a !== 8'h46) begin bad++; $display("FAIL raw_bypass: got out_a=%h expected 46", out_a); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL raw_busy_clear: got %h expected 00", busy); end
  endtask

  task automatic test_backpressure();
    next_cycle();
    out_ready = 1'b0;
    issue(4'h7, 3'd6, 1'b0, 3'd1, 3'd2, 1'b0, 8'h00);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_accept: got in_ready=%b expected 1", in_ready); end
    next_cycle();
    issue(4'h8, 3'd7, 1'b0, 3'd2, 3'd1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready%0d: got %b expected 0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || out_a !== 8'h12 || out_b !== 8'h34 || out_opcode !== 4'h7) begin
        bad++; $display("FAIL bp_hold_out%0d: got v=%b a=%h b=%h op=%h expected v=1 a=12 b=34 op=7", i, out_valid, out_a, out_b, out_opcode);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_accept: got in_ready=%b expected 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_a !== 8'h34 || out_b !== 8'h12 || out_opcode !== 4'h8) begin
      bad++; $display("FAIL bp_second_out: got a=%h b=%h op=%h expected a=34 b=12 op=8", out_a, out_b, out_opcode);
    end
    total++; if (stall_cnt !== 16'd7) begin bad++; $display("FAIL bp_stall_cnt: got %0d expected 7", stall_cnt); end
  endtask

  task automatic test_imm_bypass();
    next_cycle();
    issue(4'h9, 3'd2, 1'b1, 3'd0, 3'd0, 1'b1, 8'h01);
    next_cycle();
    issue(4'hA, 3'd1, 1'b0, 3'd0, 3'd2, 1'b1, 8'hA5);
    @(negedge clk);
    total++; if (busy !== 8'h04) begin bad++; $display("FAIL imm_busy_set: got %h expected 04", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL imm_accept: got in_ready=%b expected 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h22;
    @(negedge clk);
    total++; if (out_b !== 8'hA5 || out_a !== 8'h00) begin bad++; $display("FAIL imm_operands: got a=%h b=%h expected a=00 b=a5", out_a, out_b); end
    next_cycle();
    wb_en = 1'b0;
    @(negedge clk);
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL imm_busy_clear: got %h expected 00", busy); end
  endtask

  task automatic test_set_clear();
    next_cycle();
    issue(4'hB, 3'd4, 1'b1, 3'd1, 3'd0, 1'b1, 8'h03);
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h99;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL setclr_accept: got in_ready=%b expected 1", in_ready); end
    next_cycle();
    wb_en = 1'b0;
    issue(4'hC, 3'd0, 1'b0, 3'd4, 3'd0, 1'b1, 8'h05);
    @(negedge clk);
    total++; if (busy !== 8'h10) begin bad++; $display("FAIL setclr_busy: got %h expected 10", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL setclr_reader_stall: got in_ready=%b expected 0", in_ready); end
    next_cycle();
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h5A;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL setclr_release: got in_ready=%b expected 1", in_ready); end
    next_cycle();
    wb_en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_a !== 8'h5A) begin bad++; $display("FAIL setclr_bypass: got out_a=%h expected 5a", out_a); end
  endtask

  task automatic test_mid_reset();
    next_cycle();
    issue(4'hD, 3'd6, 1'b1, 3'd1, 3'd2, 1'b0, 8'h00);
    next_cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 8'h00 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL mid_reset: got v=%b busy=%h stall=%0d expected 0 00 0", out_valid, busy, stall_cnt);
    end
    next_cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw_stall();
    test_backpressure();
    test_imm_bypass();
    test_set_clear();
    test_mid_reset();
    repeat (3) next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
